chained_mod_counter: RTL and testbench

Parametrised cascade of modulo counters forming one multi-radix count value, e.g. seconds/minutes/hours for the clock datapath. It generalises the single-stage enabled mod-n counter to STAGES stages, each with its own modulus. It adds up/down counting, per-stage synchronous load, a terminal-count flag and a registered full-chain rollover pulse. It sits between the tick prescaler (drives `en`) and the display/alarm logic.

---
 rtl/chained_mod_counter.sv | 70 +++++++
 tb/tb_chained_mod_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/chained_mod_counter.sv
// Cascade of modulo counters forming one multi-radix value (e.g. hh:mm:ss).
// Supports up/down counting, per-stage clamped load, terminal-count and rollover pulse.
module chained_mod_counter #(
    parameter int unsigned                STAGES = 3,
    parameter int unsigned                W      = 6,
    parameter logic [STAGES*W-1:0]        MODS   = {6'd24, 6'd60, 6'd60},
    parameter int unsigned                SELW   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                up,
    input  logic                load,
    input  logic [SELW-1:0]     load_sel,
    input  logic [W-1:0]        load_val,
    output logic [STAGES*W-1:0] count,
    output logic [STAGES-1:0]   carry,
    output logic                tc,
    output logic                rollover
);

    logic [STAGES*W-1:0] count_q, count_d;
    logic [STAGES-1:0]   at_term;
    logic                rollover_q;

    always_comb begin : next_state
        logic         ripple;
        logic [W-1:0] mod_v;
        logic [W-1:0] cur;
        count_d = count_q;
        at_term = '0;
        carry   = '0;
        // A load, even to a nonexistent stage, suppresses stepping everywhere.
        ripple  = en & ~load;
        for (int i = 0; i < STAGES; i++) begin
            mod_v      = MODS[i*W +: W];
            cur        = count_q[i*W +: W];
            at_term[i] = up ? (cur == mod_v - W'(1)) : (cur == '0);
            carry[i]   = ripple & at_term[i];
            if (load) begin
                if (load_sel == SELW'(i)) begin
                    count_d[i*W +: W] = (load_val >= mod_v) ? mod_v - W'(1) : load_val;
                end
            end else if (ripple) begin
                if (up) begin
                    count_d[i*W +: W] = at_term[i] ? '0 : cur + W'(1);
                end else begin
                    count_d[i*W +: W] = at_term[i] ? mod_v - W'(1) : cur - W'(1);
                end
            end
            // Next stage steps only when this one steps from its terminal value.
            ripple = carry[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            rollover_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= carry[STAGES-1];
        end
    end

    assign count    = count_q;
    assign tc       = &at_term;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_chained_mod_counter.sv
// Directed bench for chained_mod_counter in its default hh:mm:ss configuration.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_chained_mod_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [1:0]  load_sel;
    logic [5:0]  load_val;
    logic [17:0] count;
    logic [2:0]  carry;
    logic        tc;
    logic        rollover;

    int passed = 0;
    int total  = 0;

    chained_mod_counter dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_sel (load_sel),
        .load_val (load_val),
        .count    (count),
        .carry    (carry),
        .tc       (tc),
        .rollover (rollover)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] hms(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Loads seconds, minutes, hours in three load cycles with stepping off.
    task automatic set_time(input int h, input int m, input int s);
        en = 1'b0;
        load = 1'b1;
        load_sel = 2'd0; load_val = 6'(s); tick();
        load_sel = 2'd1; load_val = 6'(m); tick();
        load_sel = 2'd2; load_val = 6'(h); tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (count !== 18'h0) $display("FAIL reset_init count: got %h want %h", count, 18'h0);
        else passed++;
        total++;
        if (rollover !== 1'b0) $display("FAIL reset_init rollover: got %b want 0", rollover);
        else passed++;
        reset = 1'b0;
        set_time(5, 30, 10);
        up = 1'b1; en = 1'b1;
        tick(); tick();
        total++;
        if (count !== hms(5, 30, 12)) $display("FAIL pre_reset count: got %h want %h", count, hms(5, 30, 12));
        else passed++;
        #2 reset = 1'b1; load = 1'b1; load_sel = 2'd1; load_val = 6'd7;
        #1;
        total++;
        if (count !== 18'h0) $display("FAIL async_reset count: got %h want %h", count, 18'h0);
        else passed++;
        total++;
        if (rollover !== 1'b0) $display("FAIL async_reset rollover: got %b want 0", rollover);
        else passed++;
        tick();
        total++;
        if (count !== 18'h0) $display("FAIL reset_load_discard count: got %h want %h", count, 18'h0);
        else passed++;
        reset = 1'b0; load = 1'b0; en = 1'b1;
        tick();
        total++;
        if (count !== hms(0, 0, 1)) $display("FAIL first_step count: got %h want %h", count, hms(0, 0, 1));
        else passed++;
        en = 1'b0;
    endtask

    task automatic test_minute_carry();
        set_time(0, 0, 59);
        up = 1'b1; en = 1'b1;
        #1;
        total++;
        if (carry !== 3'b001) $display("FAIL minute_carry carry: got %b want 001", carry);
        else passed++;
        tick();
        en = 1'b0;
        total++;
        if (count !== hms(0, 1, 0)) $display("FAIL minute_carry count: got %h want %h", count, hms(0, 1, 0));
        else passed++;
    endtask

    task automatic test_full_wrap_up();
        set_time(23, 59, 59);
        up = 1'b1; en = 1'b1;
        #1;
        total++;
        if (tc !== 1'b1) $display("FAIL wrap_up tc: got %b want 1", tc);
        else passed++;
        total++;
        if (carry !== 3'b111) $display("FAIL wrap_up carry: got %b want 111", carry);
        else passed++;
        tick();
        en = 1'b0;
        total++;
        if (count !== 18'h0) $display("FAIL wrap_up count: got %h want %h", count, 18'h0);
        else passed++;
        total++;
        if (rollover !== 1'b1) $display("FAIL wrap_up rollover_rise: got %b want 1", rollover);
        else passed++;
        tick();
        total++;
        if (rollover !== 1'b0) $display("FAIL wrap_up rollover_fall: got %b want 0", rollover);
        else passed++;
    endtask

    task automatic test_down_wrap();
        set_time(0, 0, 0);
        up = 1'b0; en = 1'b1;
        #1;
        total++;
        if (tc !== 1'b1) $display("FAIL down_wrap tc: got %b want 1", tc);
        else passed++;
        tick();
        total++;
        if (count !== hms(23, 59, 59)) $display("FAIL down_wrap count: got %h want %h", count, hms(23, 59, 59));
        else passed++;
        total++;
        if (rollover !== 1'b1) $display("FAIL down_wrap rollover_rise: got %b want 1", rollover);
        else passed++;
        tick();
        en = 1'b0; up = 1'b1;
        total++;
        if (count !== hms(23, 59, 58)) $display("FAIL down_step count: got %h want %h", count, hms(23, 59, 58));
        else passed++;
        total++;
        if (rollover !== 1'b0) $display("FAIL down_wrap rollover_fall: got %b want 0", rollover);
        else passed++;
    endtask

    task automatic test_load();
        set_time(12, 10, 7);
        up = 1'b1; en = 1'b1; load = 1'b1;
        load_sel = 2'd1; load_val = 6'd45;
        tick();
        total++;
        if (count !== hms(12, 45, 7)) $display("FAIL load_stage1 count: got %h want %h", count, hms(12, 45, 7));
        else passed++;
        load_sel = 2'd2; load_val = 6'd63;
        tick();
        total++;
        if (count !== hms(23, 45, 7)) $display("FAIL load_clamp_hour count: got %h want %h", count, hms(23, 45, 7));
        else passed++;
        load_sel = 2'd0; load_val = 6'd60;
        tick();
        total++;
        if (count !== hms(23, 45, 59)) $display("FAIL load_clamp_sec count: got %h want %h", count, hms(23, 45, 59));
        else passed++;
        load_sel = 2'd3; load_val = 6'd5;
        #1;
        total++;
        if (carry !== 3'b000) $display("FAIL load_blocks_carry carry: got %b want 000", carry);
        else passed++;
        tick();
        total++;
        if (count !== hms(23, 45, 59)) $display("FAIL load_bad_sel count: got %h want %h", count, hms(23, 45, 59));
        else passed++;
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_hold();
        set_time(12, 34, 56);
        en = 1'b0; up = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (count !== hms(12, 34, 56)) $display("FAIL hold_count[%0d]: got %h want %h", i, count, hms(12, 34, 56));
            else passed++;
            total++;
            if (carry !== 3'b000) $display("FAIL hold_carry[%0d]: got %b want 000", i, carry);
            else passed++;
            total++;
            if (rollover !== 1'b0) $display("FAIL hold_rollover[%0d]: got %b want 0", i, rollover);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp_seq [4];
        exp_seq[0] = hms(0, 0, 59);
        exp_seq[1] = hms(0, 1, 0);
        exp_seq[2] = hms(0, 1, 1);
        exp_seq[3] = hms(0, 1, 0);
        set_time(0, 0, 58);
        up = 1'b1; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            // Direction flips just before the last step and must act immediately.
            if (i == 3) up = 1'b0;
            tick();
            total++;
            if (count !== exp_seq[i]) $display("FAIL back_to_back[%0d] count: got %h want %h", i, count, exp_seq[i]);
            else passed++;
        end
        en = 1'b0; up = 1'b1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0;
        load_sel = 2'd0; load_val = 6'd0;
        tick(); tick();
        test_reset();
        test_minute_carry();
        test_full_wrap_up();
        test_down_wrap();
        test_load();
        test_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
